// File: rtl/fpu_bus_slave_pkg.sv
// Shared FPU definitions: operation codes, host register map, bus FSM states,
// status bit positions and the quiet-NaN pattern.
package pa_fpu;

  typedef enum logic [7:0] {
    OP_ADD  = 8'h01,
    OP_SUB  = 8'h02,
    OP_MUL  = 8'h03,
    OP_DIV  = 8'h04,
    OP_SQRT = 8'h05,
    OP_FTOI = 8'h06,
    OP_ITOF = 8'h07
  } e_fpu_operation;

  localparam int REG_OPA0   = 0;
  localparam int REG_OPB0   = 4;
  localparam int REG_CMD    = 8;
  localparam int REG_RES0   = 9;
  localparam int REG_STATUS = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ACK  = 2'd3
  } e_bus_state;

  localparam int ST_BUSY    = 0;
  localparam int ST_CMD_END = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_TIMEOUT = 3;

  localparam logic [31:0] QNAN = 32'h7FC00000;

endpackage

// File: rtl/fpu_bus_slave_if.sv
// Host bus seen by the FPU register block: byte data, address, active-low
// strobes and the cmd_end/end_ack completion handshake.
interface fpu_bus_slave_if #(
  parameter int ADDR_W = 4
) ();
  logic [7:0]        databus_in;
  logic [7:0]        databus_out;
  logic [ADDR_W-1:0] addr;
  logic              cs;
  logic              rd;
  logic              wr;
  logic              end_ack;
  logic              cmd_end;
  logic              busy;

  modport slave (
    input  databus_in, addr, cs, rd, wr, end_ack,
    output databus_out, cmd_end, busy
  );

  modport master (
    output databus_in, addr, cs, rd, wr, end_ack,
    input  databus_out, cmd_end, busy
  );
endinterface

// File: rtl/fpu_bus_slave_wr_strobe.sv
// Falling-edge detector for an active-low bus strobe: one-cycle pulse per
// low pulse while selected, however long the strobe is held.
module fpu_wr_strobe (
  input  logic clk,
  input  logic arst_n,
  input  logic cs,
  input  logic wr,
  output logic wr_stb
);
  logic wr_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) wr_q <= 1'b1;
    else         wr_q <= wr;
  end

  assign wr_stb = !cs && !wr && wr_q;
endmodule

// File: rtl/fpu_bus_slave.sv
// Host register block and command sequencer of the FPU.
// Optional core watchdog enabled by defining FPU_TIMEOUT_EN.
module fpu_bus_slave
  import pa_fpu::*;
#(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              arst_n,
  fpu_bus_slave_if.slave    bus,
  output logic [31:0]       op_a,
  output logic [31:0]       op_b,
  output logic [7:0]        operation,
  output logic              core_start,
  input  logic              core_done,
  input  logic [31:0]       core_result
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);
  localparam logic [1:0] S_ACK  = 2'(ACK);

  logic        wr_stb, rd_stb;
  logic        cmd_wr, op_wr, status_rd, expire, timeout_flag;
  logic [1:0]  state_q, state_d;
  logic [31:0] op_a_q, op_b_q, result_q;
  logic [7:0]  operation_q, status, rd_data;
  logic        core_start_q, overrun_q;

  fpu_wr_strobe u_wr_strobe (
    .clk    (clk),
    .arst_n (arst_n),
    .cs     (bus.cs),
    .wr     (bus.wr),
    .wr_stb (wr_stb)
  );

  // Same edge detector on rd: status flags clear only on the first read cycle.
  fpu_wr_strobe u_rd_strobe (
    .clk    (clk),
    .arst_n (arst_n),
    .cs     (bus.cs),
    .wr     (bus.rd),
    .wr_stb (rd_stb)
  );

  assign cmd_wr    = wr_stb && (bus.addr == ADDR_W'(REG_CMD));
  assign op_wr     = wr_stb && (state_q != S_RUN);
  assign status_rd = rd_stb && (bus.addr == ADDR_W'(REG_STATUS));

`ifdef FPU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_q;

  assign expire       = (state_q == S_RUN) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES));
  assign timeout_flag = timeout_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q != S_RUN) tmo_cnt_q <= '0;
      else if (!expire)     tmo_cnt_q <= tmo_cnt_q + 1'b1;
      // A real result arriving on the expiry cycle takes precedence.
      if (expire && !core_done) timeout_q <= 1'b1;
      else if (status_rd)       timeout_q <= 1'b0;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo   = (TIMEOUT_CYCLES > 0);
  assign expire       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_wr) state_d = S_RUN;
      S_RUN:   if (core_done || expire) state_d = S_DONE;
      S_DONE:  if (bus.end_ack) state_d = S_ACK;
      S_ACK:   if (!bus.end_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      operation_q  <= '0;
      result_q     <= '0;
      core_start_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_start_q <= (state_q == S_IDLE) && cmd_wr;
      if ((state_q == S_IDLE) && cmd_wr) operation_q <= bus.databus_in;
      if (state_q == S_RUN) begin
        if (core_done)   result_q <= core_result;
        else if (expire) result_q <= QNAN;
      end
      // A new overrun in the clearing cycle survives the read.
      if (cmd_wr && (state_q != S_IDLE)) overrun_q <= 1'b1;
      else if (status_rd)                overrun_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (op_wr && (bus.addr == ADDR_W'(REG_OPA0 + i))) op_a_q[8*i +: 8] <= bus.databus_in;
        if (op_wr && (bus.addr == ADDR_W'(REG_OPB0 + i))) op_b_q[8*i +: 8] <= bus.databus_in;
      end
    end
  end

  always_comb begin
    status              = '0;
    status[ST_BUSY]     = (state_q == S_RUN);
    status[ST_CMD_END]  = (state_q == S_DONE);
    status[ST_OVERRUN]  = overrun_q;
    status[ST_TIMEOUT]  = timeout_flag;
  end

  always_comb begin
    rd_data = 8'h00;
    case (bus.addr)
      ADDR_W'(REG_RES0):     rd_data = result_q[7:0];
      ADDR_W'(REG_RES0 + 1): rd_data = result_q[15:8];
      ADDR_W'(REG_RES0 + 2): rd_data = result_q[23:16];
      ADDR_W'(REG_RES0 + 3): rd_data = result_q[31:24];
      ADDR_W'(REG_STATUS):   rd_data = status;
      default:               rd_data = 8'h00;
    endcase
  end

  assign bus.databus_out = (!bus.cs && !bus.rd) ? rd_data : 8'h00;
  assign bus.busy        = (state_q == S_RUN);
  assign bus.cmd_end     = (state_q == S_DONE);
  assign op_a            = op_a_q;
  assign op_b            = op_b_q;
  assign operation       = operation_q;
  assign core_start      = core_start_q;

endmodule

// File: tb/tb_fpu_bus_slave.sv
// Directed plus randomized bench for fpu_bus_slave against a byte-level
// model of the host register map and command handshake.
module tb_fpu_bus_slave;
  import pa_fpu::*;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [31:0] op_a, op_b, core_result;
  logic [7:0]  operation;
  logic        core_start, core_done;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  logic [31:0] exp_a, exp_b, exp_res;
  logic [7:0]  exp_op, rdata;
  logic        exp_overrun, exp_timeout;

  fpu_bus_slave_if #(.ADDR_W(4)) bus ();

  fpu_bus_slave #(.ADDR_W(4), .TIMEOUT_CYCLES(20)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .bus         (bus),
    .op_a        (op_a),
    .op_b        (op_b),
    .operation   (operation),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (core_start === 1'b1) start_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: a register read returns the result byte, the status byte, or zero.
  function automatic logic [7:0] model_read(input int a, input logic m_busy, input logic m_end);
    if (a >= 9 && a <= 12) return 8'(exp_res >> (8 * (a - 9)));
    if (a == 13) return {4'h0, exp_timeout, exp_overrun, m_end, m_busy};
    return 8'h00;
  endfunction

  function automatic void model_write(input int a, input logic [7:0] d);
    if (a < 4)                exp_a[8*a +: 8] = d;
    else if (a >= 4 && a < 8) exp_b[8*(a-4) +: 8] = d;
  endfunction

  task automatic wr_reg(input int a, input logic [7:0] d);
    @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0; bus.addr = 4'(a); bus.databus_in = d;
    @(negedge clk);
    bus.wr = 1'b1; bus.cs = 1'b1;
  endtask

  task automatic rd_reg(input int a, output logic [7:0] d);
    @(negedge clk);
    bus.cs = 1'b0; bus.rd = 1'b0; bus.addr = 4'(a);
    #1 d = bus.databus_out;
    @(negedge clk);
    bus.rd = 1'b1; bus.cs = 1'b1;
  endtask

  task automatic issue_cmd(input logic [7:0] op);
    @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0; bus.addr = 4'(REG_CMD); bus.databus_in = op;
    #1 check("start_before_edge", core_start, 1'b0);
    @(negedge clk);
    check("start_pulse", core_start, 1'b1);
    check("busy_in_run", bus.busy, 1'b1);
    check("operation", operation, op);
    bus.wr = 1'b1; bus.cs = 1'b1;
    @(negedge clk);
    check("start_single", core_start, 1'b0);
  endtask

  task automatic finish_cmd(input int wait_cyc, input logic [31:0] r);
    repeat (wait_cyc) @(negedge clk);
    check("busy_before_done", bus.busy, 1'b1);
    core_done = 1'b1; core_result = r;
    #1 check("cmd_end_not_early", bus.cmd_end, 1'b0);
    @(negedge clk);
    core_done = 1'b0; core_result = $urandom;
    check("cmd_end_rise", bus.cmd_end, 1'b1);
    check("busy_after_done", bus.busy, 1'b0);
  endtask

  task automatic ack_cmd();
    @(negedge clk); bus.end_ack = 1'b1;
    @(negedge clk);
    check("cmd_end_fall", bus.cmd_end, 1'b0);
    bus.end_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_result_bytes(input string tag);
    for (int a = 9; a <= 12; a++) begin
      rd_reg(a, rdata);
      check(tag, rdata, model_read(a, 1'b0, 1'b1));
    end
  endtask

  task automatic wait_cmd_end(input int budget, output int n);
    n = 0;
    while (bus.cmd_end !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, cnt0;
    logic [31:0] r;
    logic [7:0]  op;
    bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = '0;
    bus.databus_in = '0; bus.end_ack = 1'b0;
    core_done = 1'b0; core_result = '0;
    exp_a = '0; exp_b = '0; exp_res = '0; exp_op = '0;
    exp_overrun = 1'b0; exp_timeout = 1'b0;
    arst_n = 1'b0;

    #12;
    check("rst_op_a", op_a, 32'h0);
    check("rst_op_b", op_b, 32'h0);
    check("rst_operation", operation, 8'h0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cmd_end", bus.cmd_end, 1'b0);
    @(negedge clk); arst_n = 1'b1;

    // Operand load through the byte registers.
    for (int i = 0; i < 4; i++) begin
      wr_reg(REG_OPA0 + i, 8'(32'h43a9ab64 >> (8 * i)));
      wr_reg(REG_OPB0 + i, 8'(32'hc479fff0 >> (8 * i)));
    end
    exp_a = 32'h43a9ab64; exp_b = 32'hc479fff0;
    check("op_a_load", op_a, exp_a);
    check("op_b_load", op_b, exp_b);
    rd_reg(REG_STATUS, rdata);
    check("status_idle", rdata, 8'h00);
    rd_reg(REG_OPA0, rdata);
    check("op_a_write_only", rdata, 8'h00);

    // Add command; operand write while running must be dropped.
    issue_cmd(OP_ADD);
    exp_op = OP_ADD;
    wr_reg(REG_OPA0, 8'hEE);
    check("op_a_locked_in_run", op_a, exp_a);
    rd_reg(REG_STATUS, rdata);
    check("status_run", rdata, 8'h01);
    finish_cmd(3, 32'hc4252a3d);
    exp_res = 32'hc4252a3d;
    check("start_count_1", start_cnt, 1);
    check_result_bytes("result_add");
    rd_reg(REG_STATUS, rdata);
    check("status_done", rdata, 8'h02);

    // Stuck acknowledge: second command in ACK is an overrun.
    @(negedge clk); bus.end_ack = 1'b1;
    @(negedge clk);
    check("cmd_end_drop_on_ack", bus.cmd_end, 1'b0);
    wr_reg(REG_CMD, OP_SUB);
    wr_reg(REG_OPB0 + 3, 8'h12);
    model_write(REG_OPB0 + 3, 8'h12);
    repeat (2) @(negedge clk);
    check("overrun_no_start", start_cnt, 1);
    check("overrun_op_kept", operation, exp_op);
    check("op_b_write_in_ack", op_b, exp_b);
    check("cmd_end_held_ack", bus.cmd_end, 1'b0);
    rd_reg(REG_STATUS, rdata);
    check("status_overrun", rdata, 8'h04);
    rd_reg(REG_STATUS, rdata);
    check("status_overrun_cleared", rdata, 8'h00);
    bus.end_ack = 1'b0;
    @(negedge clk);

    // Randomized commands against the model.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 5; k++) begin
        int a;
        logic [7:0] d;
        a = $urandom_range(0, 15);
        if (a == REG_CMD) a = 14;
        d = 8'($urandom);
        wr_reg(a, d);
        model_write(a, d);
      end
      check("rand_op_a", op_a, exp_a);
      check("rand_op_b", op_b, exp_b);
      @(negedge clk); core_done = 1'b1; core_result = $urandom;
      @(negedge clk); core_done = 1'b0;
      check("idle_done_ignored", bus.cmd_end, 1'b0);
      op = 8'($urandom_range(1, 7));
      issue_cmd(op);
      exp_op = op;
      r = $urandom;
      finish_cmd($urandom_range(0, 8), r);
      exp_res = r;
      check_result_bytes("rand_result");
      wr_reg(REG_OPA0 + it % 4, 8'(it + 8'h30));
      model_write(it % 4, 8'(it + 8'h30));
      check("op_a_write_in_done", op_a, exp_a);
      ack_cmd();
      rd_reg(REG_STATUS, rdata);
      check("rand_status_idle", rdata, model_read(REG_STATUS, 1'b0, 1'b0));
    end
    check("rand_start_count", start_cnt, 7);

    // Long write pulse: only the first cycle's data is captured.
    @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0; bus.addr = 4'(REG_OPB0); bus.databus_in = 8'h55;
    @(negedge clk); bus.databus_in = 8'hAA;
    @(negedge clk);
    @(negedge clk); bus.wr = 1'b1; bus.cs = 1'b1;
    model_write(REG_OPB0, 8'h55);
    check("held_wr_op_b", op_b, exp_b);
    check("held_wr_op_a", op_a, exp_a);

    // Reset in the middle of RUN, then a late core_done.
    cnt0 = start_cnt;
    issue_cmd(OP_MUL);
    #2 arst_n = 1'b0;
    #1;
    check("mid_rst_op_a", op_a, 32'h0);
    check("mid_rst_op_b", op_b, 32'h0);
    check("mid_rst_operation", operation, 8'h0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_cmd_end", bus.cmd_end, 1'b0);
    check("mid_rst_core_start", core_start, 1'b0);
    bus.cs = 1'b0; bus.rd = 1'b0; bus.addr = 4'(REG_RES0 + 3);
    #1 check("mid_rst_databus", bus.databus_out, 8'h00);
    bus.cs = 1'b1; bus.rd = 1'b1;
    exp_a = '0; exp_b = '0; exp_res = '0; exp_op = '0;
    @(negedge clk); arst_n = 1'b1;
    @(negedge clk); core_done = 1'b1; core_result = 32'hdeadbeef;
    @(negedge clk); core_done = 1'b0;
    repeat (3) @(negedge clk);
    check("late_done_cmd_end", bus.cmd_end, 1'b0);
    check("late_done_busy", bus.busy, 1'b0);
    rd_reg(REG_RES0 + 3, rdata);
    check("late_done_result", rdata, 8'h00);
    rd_reg(REG_STATUS, rdata);
    check("post_rst_status", rdata, 8'h00);
    check("post_rst_no_start", start_cnt, cnt0 + 1);

    // Core that never answers.
    issue_cmd(OP_DIV);
`ifdef FPU_TIMEOUT_EN
    // issue_cmd returns one clock after the start pulse.
    wait_cmd_end(100, n);
    check("timeout_latency", n + 1, 21);
    exp_res = QNAN; exp_timeout = 1'b1;
    check_result_bytes("timeout_result");
    rd_reg(REG_STATUS, rdata);
    check("status_timeout", rdata, 8'h0A);
    exp_timeout = 1'b0;
    rd_reg(REG_STATUS, rdata);
    check("status_timeout_cleared", rdata, 8'h02);
    ack_cmd();
`else
    wait_cmd_end(300, n);
    check("no_timeout_wait", n, 300);
    check("no_timeout_busy", bus.busy, 1'b1);
    rd_reg(REG_STATUS, rdata);
    check("status_no_timeout", rdata, 8'h01);
    finish_cmd(0, 32'h3f800000);
    exp_res = 32'h3f800000;
    check_result_bytes("late_result");
    ack_cmd();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
